mlp_collector_axis_bridge: RTL and testbench

Downstream stage of `mlp_1`: drains the collector output FIFO through its `collector_ofifo_rdy`/`collector_ofifo_ren`/`collector_ofifo_rdata` read port. Results are buffered locally and re-emitted as an AXI-Stream master with `tlast` framing every `BURST_LEN` words. A flush request closes a partial burst so the NoC egress sees clean packet boundaries.

---
 rtl/mlp_collector_pkg.sv | 15 +
 rtl/collector_sync_fifo.sv | 51 +++++
 rtl/mlp_collector_axis_bridge.sv | 96 +++++++++
 tb/tb_mlp_collector_axis_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_collector_pkg.sv
// mlp_collector_pkg: shared types and sizing for the collector-to-AXIS bridge.
//   state_t        bridge FSM states (RUN, DRAIN, DONE)
//   DATA_WIDTH_DEF default result word width
//   DEPTH_DEF      default local buffer depth
//   OCC_W_DEF      occupancy counter width for the default depth
//   occ_width()    occupancy width able to hold 0..depth
package mlp_collector_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int DEPTH_DEF = 8;
    localparam int OCC_W_DEF = $clog2(DEPTH_DEF) + 1;
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/collector_sync_fifo.sv
// collector_sync_fifo: first-word-fall-through FIFO.
//   clk, reset (async, active-low)
//   i_push/i_din  write side; i_pop pops the head when not empty
//   o_dout        head word, zero while empty
//   o_full, o_empty, o_count  occupancy status
module collector_sync_fifo
    import mlp_collector_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic w_push;
    logic w_pop;
    assign w_pop = i_pop & ~o_empty;
    // a pop in the same cycle frees the slot, so push-while-full is legal then
    assign w_push = i_push & (~o_full | w_pop);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd <= '0;
            r_wr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
    assign o_empty = r_count == '0;
    assign o_full = r_count == CW'(DEPTH);
    assign o_dout = o_empty ? '0 : r_mem[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/mlp_collector_axis_bridge.sv
// mlp_collector_axis_bridge: drains the mlp_1 collector output FIFO into a local
// buffer and re-emits it as an AXI-Stream master, framing tlast every BURST_LEN
// words; flush closes a partial packet and acknowledges with flush_done.
//   clk, reset (async, active-low)
//   collector_ofifo_rdy/ren/rdata  upstream read port (rdata valid cycle after ren)
//   m_axis_tdata/tvalid/tlast/tready  stream master
//   flush (level), flush_done (one-cycle pulse)
//   stat_words, stat_stalls  only when MLP_COLLECTOR_STATS_EN is defined
module mlp_collector_axis_bridge
    import mlp_collector_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  collector_ofifo_rdy,
    output logic                  collector_ofifo_ren,
    input  logic [DATA_WIDTH-1:0] collector_ofifo_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic                  flush,
    output logic                  flush_done
`ifdef MLP_COLLECTOR_STATS_EN
    ,
    output logic [31:0]           stat_words,
    output logic [31:0]           stat_stalls
`endif
);
    localparam int CW = occ_width(DEPTH);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    state_t r_state;
    logic r_inflight;
    logic [BW-1:0] r_beat;
    logic [CW-1:0] w_count;
    logic w_empty;
    logic w_full;
    logic w_drain;
    logic w_zero;
    logic w_hs;
    collector_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .i_push(r_inflight),
        .i_din(collector_ofifo_rdata),
        .i_pop(m_axis_tready),
        .o_dout(m_axis_tdata),
        .o_full(w_full),
        .o_empty(w_empty),
        .o_count(w_count)
    );
    assign w_drain = r_state == ST_DRAIN;
    // the in-flight word already owns a slot, so it counts against the credit
    assign collector_ofifo_ren = reset & collector_ofifo_rdy & ~w_full & (r_state == ST_RUN)
                               & (int'(w_count) + int'(r_inflight) < DEPTH);
    // packet left open with nothing to send: close it with a zero-data word
    assign w_zero = w_drain & w_empty & ~r_inflight & (r_beat != '0);
    assign m_axis_tvalid = ~w_empty | w_zero;
    assign m_axis_tlast = m_axis_tvalid & ((r_beat == BW'(BURST_LEN - 1))
                        | (w_drain & ~r_inflight & ((w_count == CW'(1)) | w_empty)));
    assign w_hs = m_axis_tvalid & m_axis_tready;
    assign flush_done = r_state == ST_DONE;
    // beat == 0 outside DONE means the last accepted word carried tlast
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_inflight <= 1'b0;
            r_beat <= '0;
        end else begin
            r_inflight <= collector_ofifo_ren;
            if (r_state == ST_DONE) r_beat <= '0;
            else if (w_hs) r_beat <= m_axis_tlast ? '0 : r_beat + BW'(1);
            r_state <= (r_state == ST_RUN) ? (flush ? ST_DRAIN : ST_RUN)
                     : (r_state == ST_DRAIN) ? ((w_empty & ~r_inflight & (r_beat == '0)) ? ST_DONE : ST_DRAIN)
                     : ST_RUN;
        end
    end
`ifdef MLP_COLLECTOR_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_stalls;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_words <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_hs) r_stat_words <= r_stat_words + 32'd1;
            if (m_axis_tvalid & ~m_axis_tready) r_stat_stalls <= r_stat_stalls + 32'd1;
        end
    end
    assign stat_words = r_stat_words;
    assign stat_stalls = r_stat_stalls;
`endif
endmodule

// File: tb/tb_mlp_collector_axis_bridge.sv
// tb_mlp_collector_axis_bridge: scoreboard bench for the collector AXIS bridge.
module tb_mlp_collector_axis_bridge;
    localparam int DW = 64;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rdy;
    logic ren;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] tdata;
    logic tvalid;
    logic tlast;
    logic tready = 1'b0;
    logic flush = 1'b0;
    logic flush_done;
`ifdef MLP_COLLECTOR_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_stalls;
`endif
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] up_words [256];
    int up_wr = 0;
    int up_rd = 0;
    logic [DW:0] exp_q [$];
    logic [DW:0] got_q [$];
    int cyc = 0;
    int ren_cnt = 0;
    int fd_cnt = 0;
    int ren_bad = 0;
    int first_ren = -1;
    int first_tv = -1;
    bit drain_win = 0;

    always #5 clk = ~clk;

    // upstream collector FIFO model: rdata is valid the cycle after ren
    assign rdy = up_rd != up_wr;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren) begin
            rdata <= up_words[up_rd & 255];
            up_rd <= up_rd + 1;
            ren_cnt <= ren_cnt + 1;
        end
    end

    mlp_collector_axis_bridge #(.DATA_WIDTH(DW), .DEPTH(8), .BURST_LEN(4)) dut (
        .clk(clk),
        .reset(reset),
        .collector_ofifo_rdy(rdy),
        .collector_ofifo_ren(ren),
        .collector_ofifo_rdata(rdata),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tlast(tlast),
        .m_axis_tready(tready),
        .flush(flush),
        .flush_done(flush_done)
`ifdef MLP_COLLECTOR_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_stalls(stat_stalls)
`endif
    );

    task automatic push_word(input logic [DW-1:0] d, input bit last, input bit expect_it);
        up_words[up_wr & 255] = d;
        up_wr++;
        if (expect_it) exp_q.push_back({last, d});
    endtask

    // records upcoming handshakes (sampled at negedge) plus side observations
    task automatic collect(input int n, input int maxc);
        int k = 0;
        got_q.delete();
        while (got_q.size() < n && k < maxc) begin
            @(negedge clk);
            k++;
            if (ren && first_ren < 0) first_ren = cyc;
            if (tvalid && first_tv < 0) first_tv = cyc;
            if (drain_win && ren) ren_bad++;
            if (flush_done) begin
                fd_cnt++;
                drain_win = 0;
            end
            if (tvalid && tready) got_q.push_back({tlast, tdata});
        end
    endtask

    task automatic test_reset();
        tready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(DW'(i), (i % 4) == 0, 1'b1);
        #12;
        checks++;
        if (ren !== 1'b0) begin failures++; $display("FAIL reset_ren got=%b exp=0", ren); end
        checks++;
        if ({tvalid, tlast, flush_done} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {tvalid, tlast, flush_done}); end
        checks++;
        if (tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
`ifdef MLP_COLLECTOR_STATS_EN
        checks++;
        if ({stat_words, stat_stalls} !== 64'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_words, stat_stalls); end
`endif
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [DW:0] e;
        first_ren = -1;
        first_tv = -1;
        collect(8, 60);
        checks++;
        if (first_tv - first_ren !== 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", first_tv - first_ren); end
        checks++;
        if (got_q.size() != 8) begin failures++; $display("FAIL stream_len got=%0d exp=8", got_q.size()); end
        foreach (got_q[i]) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '1;
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL stream_word[%0d] got last=%b data=%h exp last=%b data=%h", i, got_q[i][DW], got_q[i][DW-1:0], e[DW], e[DW-1:0]); end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [DW:0] e;
        int r0;
        int bad = 0;
        bit seen = 0;
        @(posedge clk);
        #1 tready = 1'b0;
        r0 = ren_cnt;
        for (int i = 1; i <= 12; i++) push_word(DW'(i), (i % 4) == 0, 1'b1);
        repeat (20) begin
            @(negedge clk);
            if (tvalid) seen = 1;
            if (seen && (!tvalid || tdata !== DW'(1))) bad++;
        end
        checks++;
        if (ren_cnt - r0 != 8) begin failures++; $display("FAIL bp_ren_count got=%0d exp=8", ren_cnt - r0); end
        checks++;
        if (tvalid !== 1'b1 || tdata !== DW'(1)) begin failures++; $display("FAIL bp_head got valid=%b data=%h exp valid=1 data=1", tvalid, tdata); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad); end
        @(posedge clk);
        #1 tready = 1'b1;
        collect(12, 80);
        checks++;
        if (got_q.size() != 12) begin failures++; $display("FAIL bp_len got=%0d exp=12", got_q.size()); end
        foreach (got_q[i]) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '1;
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL bp_word[%0d] got last=%b data=%h exp last=%b data=%h", i, got_q[i][DW], got_q[i][DW-1:0], e[DW], e[DW-1:0]); end
        end
        exp_q.delete();
    endtask

    task automatic test_flush();
        logic [DW:0] e;
        @(posedge clk);
        #1 tready = 1'b0;
        for (int i = 1; i <= 6; i++) push_word(DW'(i), i == 4 || i == 6, 1'b1);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        drain_win = 1;
        fd_cnt = 0;
        ren_bad = 0;
        push_word(DW'(7), 1'b0, 1'b1);
        push_word(DW'(8), 1'b0, 1'b1);
        tready = 1'b1;
        collect(8, 80);
        checks++;
        if (got_q.size() != 8) begin failures++; $display("FAIL flush_len got=%0d exp=8", got_q.size()); end
        foreach (got_q[i]) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '1;
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL flush_word[%0d] got last=%b data=%h exp last=%b data=%h", i, got_q[i][DW], got_q[i][DW-1:0], e[DW], e[DW-1:0]); end
        end
        exp_q.delete();
        checks++;
        if (fd_cnt != 1) begin failures++; $display("FAIL flush_done_pulses got=%0d exp=1", fd_cnt); end
        checks++;
        if (ren_bad != 0) begin failures++; $display("FAIL flush_ren_in_drain got=%0d exp=0", ren_bad); end
    endtask

    task automatic test_flush_empty();
        logic [DW:0] e;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_q.push_back({1'b1, DW'(0)});
        fd_cnt = 0;
        drain_win = 1;
        collect(1, 20);
        repeat (6) begin
            @(negedge clk);
            if (flush_done) fd_cnt++;
        end
        checks++;
        if (got_q.size() != 1) begin failures++; $display("FAIL fe_len got=%0d exp=1", got_q.size()); end
        foreach (got_q[i]) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '1;
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL fe_word got last=%b data=%h exp last=%b data=%h", got_q[i][DW], got_q[i][DW-1:0], e[DW], e[DW-1:0]); end
        end
        exp_q.delete();
        checks++;
        if (fd_cnt != 1) begin failures++; $display("FAIL fe_flush_done got=%0d exp=1", fd_cnt); end
        checks++;
        if (tvalid !== 1'b0) begin failures++; $display("FAIL fe_idle_valid got=%b exp=0", tvalid); end
        drain_win = 0;
    endtask

    task automatic test_reset_midburst();
        logic [DW:0] e;
        @(posedge clk);
        #1 tready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(32'h21 + i), 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (tvalid !== 1'b1 || tdata !== DW'(32'h21)) begin failures++; $display("FAIL mid_pre got valid=%b data=%h exp valid=1 data=21", tvalid, tdata); end
        push_word(DW'(32'hA), 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        checks++;
        if ({ren, tvalid, tlast, flush_done} !== 4'b0000) begin failures++; $display("FAIL mid_async_flags got=%b exp=0000", {ren, tvalid, tlast, flush_done}); end
        checks++;
        if (tdata !== '0) begin failures++; $display("FAIL mid_async_tdata got=%h exp=0", tdata); end
`ifdef MLP_COLLECTOR_STATS_EN
        checks++;
        if ({stat_words, stat_stalls} !== 64'd0) begin failures++; $display("FAIL mid_stats got=%0d/%0d exp=0/0", stat_words, stat_stalls); end
`endif
        push_word(DW'(32'hB), 1'b0, 1'b1);
        push_word(DW'(32'hC), 1'b0, 1'b1);
        push_word(DW'(32'hD), 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tready = 1'b1;
        collect(4, 40);
        checks++;
        if (got_q.size() != 4) begin failures++; $display("FAIL mid_len got=%0d exp=4", got_q.size()); end
        foreach (got_q[i]) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '1;
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL mid_word[%0d] got last=%b data=%h exp last=%b data=%h", i, got_q[i][DW], got_q[i][DW-1:0], e[DW], e[DW-1:0]); end
        end
        exp_q.delete();
    endtask

`ifdef MLP_COLLECTOR_STATS_EN
    task automatic test_stats();
        logic [DW:0] e;
        logic [31:0] w0;
        logic [31:0] s0;
        int k = 0;
        @(posedge clk);
        #1 tready = 1'b0;
        w0 = stat_words;
        s0 = stat_stalls;
        for (int i = 1; i <= 8; i++) push_word(DW'(32'h30 + i), (i % 4) == 0, 1'b1);
        do begin
            @(negedge clk);
            k++;
        end while (!tvalid && k < 20);
        repeat (5) @(negedge clk);
        tready = 1'b1;
        collect(8, 40);
        @(negedge clk);
        checks++;
        if (got_q.size() != 8) begin failures++; $display("FAIL stats_len got=%0d exp=8", got_q.size()); end
        foreach (got_q[i]) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '1;
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL stats_word[%0d] got last=%b data=%h exp last=%b data=%h", i, got_q[i][DW], got_q[i][DW-1:0], e[DW], e[DW-1:0]); end
        end
        exp_q.delete();
        checks++;
        if (stat_words - w0 !== 32'd8) begin failures++; $display("FAIL stat_words got=%0d exp=8", stat_words - w0); end
        checks++;
        if (stat_stalls - s0 !== 32'd5) begin failures++; $display("FAIL stat_stalls got=%0d exp=5", stat_stalls - s0); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_empty();
        test_reset_midburst();
`ifdef MLP_COLLECTOR_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
